// File: rtl/mult_exhaustive_evaluator.sv
`default_nettype none
// ============================================================================
//  Module   : mult_exhaustive_evaluator
//  Purpose  : Sweeps every A/B operand pair through a WIDTH x WIDTH multiplier
//             candidate, checks each returned P against the exact product and
//             accumulates error-count, error-sum, max-error and worst-case pair.
//  Revision : 1.0  initial release
// ============================================================================
module mult_exhaustive_evaluator #(
  parameter int WIDTH    = 4,
  parameter int PIPE_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  input  logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_count,
  output logic [4*WIDTH-1:0]   err_sum,
  output logic [2*WIDTH-1:0]   max_err,
  output logic [WIDTH-1:0]     wce_A,
  output logic [WIDTH-1:0]     wce_B
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

  localparam logic [IW-1:0] c_idx_one   = IW'(1);
  localparam logic [CW-1:0] c_drain_one = CW'(1);
  localparam logic [CW-1:0] c_drain_ini = CW'(PIPE_LAT);
  localparam logic [IW:0]   c_cnt_one   = (IW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_drain;

  logic            w_launch;
  logic            w_in_valid;
  logic [IW-1:0]   w_in_exact;
  logic            w_tag_valid;
  logic [WIDTH-1:0] w_tag_a;
  logic [WIDTH-1:0] w_tag_b;
  logic [IW-1:0]   w_tag_exact;
  logic [IW-1:0]   w_diff;

  // Start is honoured only when no sweep is in flight.
  assign w_launch   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Operands come straight from the sweep index; idx is held after the last
  // pair, so A/B keep their final values through DRAIN and DONE.
  assign A          = r_idx[WIDTH-1:0];
  assign B          = r_idx[IW-1:WIDTH];
  assign w_in_valid = (r_state == S_RUN);
  assign w_in_exact = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // The reference tag must travel alongside the candidate's own latency.
  generate
    if (PIPE_LAT == 0) begin : g_direct
      assign w_tag_valid = w_in_valid;
      assign w_tag_a     = A;
      assign w_tag_b     = B;
      assign w_tag_exact = w_in_exact;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] r_v;
      logic [WIDTH-1:0]    r_a  [PIPE_LAT];
      logic [WIDTH-1:0]    r_b  [PIPE_LAT];
      logic [IW-1:0]       r_ex [PIPE_LAT];

      // Tag delay line, one stage per cycle of candidate latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= '0;
          for (int i = 0; i < PIPE_LAT; i++) begin
            r_a[i]  <= '0;
            r_b[i]  <= '0;
            r_ex[i] <= '0;
          end
        end else begin
          r_v[0]  <= w_in_valid;
          r_a[0]  <= A;
          r_b[0]  <= B;
          r_ex[0] <= w_in_exact;
          for (int i = 1; i < PIPE_LAT; i++) begin
            r_v[i]  <= r_v[i-1];
            r_a[i]  <= r_a[i-1];
            r_b[i]  <= r_b[i-1];
            r_ex[i] <= r_ex[i-1];
          end
        end
      end

      assign w_tag_valid = r_v[PIPE_LAT-1];
      assign w_tag_a     = r_a[PIPE_LAT-1];
      assign w_tag_b     = r_b[PIPE_LAT-1];
      assign w_tag_exact = r_ex[PIPE_LAT-1];
    end
  endgenerate

  // Absolute error between candidate output and the aligned exact product.
  assign w_diff = (P >= w_tag_exact) ? (P - w_tag_exact) : (w_tag_exact - P);

  // Sweep sequencer with registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_drain <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_idx   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_idx == {IW{1'b1}}) begin
            if (PIPE_LAT == 0) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
              r_drain <= c_drain_ini;
            end
          end else begin
            r_idx <= r_idx + c_idx_one;
          end
        end
        S_DRAIN: begin
          if (r_drain == c_drain_one) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_drain <= r_drain - c_drain_one;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Error metrics: cleared on launch, updated on every valid aligned tag.
  always_ff @(posedge clk) begin
    if (rst || w_launch) begin
      err_count <= '0;
      err_sum   <= '0;
      max_err   <= '0;
      wce_A     <= '0;
      wce_B     <= '0;
    end else if (w_tag_valid) begin
      if (w_diff != '0) begin
        err_count <= err_count + c_cnt_one;
      end
      err_sum <= err_sum + {{IW{1'b0}}, w_diff};
      // Strict compare: ties keep the earliest offending pair.
      if (w_diff > max_err) begin
        max_err <= w_diff;
        wce_A   <= w_tag_a;
        wce_B   <= w_tag_b;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_exhaustive_evaluator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_exhaustive_evaluator
//  Purpose  : Self-checking bench for mult_exhaustive_evaluator with table,
//             pipelined and misaligned multiplier candidates.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_exhaustive_evaluator;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start2 = 1'b0, startm = 1'b0;

  logic [W-1:0]   A0, B0, A2, B2, Am, Bm;
  logic [2*W-1:0] P0, P2, Pm;
  logic           busy0, done0, busy2, done2, busym, donem;
  logic [2*W:0]   cnt0, cnt2, cntm;
  logic [4*W-1:0] sum0, sum2, summ;
  logic [2*W-1:0] max0, max2, maxm;
  logic [W-1:0]   wa0, wb0, wa2, wb2, wam, wbm;

  // Candidate models
  logic [7:0] tbl [256];
  logic [7:0] s1_2, s2_2, s1_m, s2_m;
  int         mp [256];

  assign P0 = tbl[{B0, A0}];
  assign P2 = s2_2;
  assign Pm = s2_m;

  always @(posedge clk) begin
    s1_2 <= {4'b0, A2} * {4'b0, B2};
    s2_2 <= s1_2;
    s1_m <= {4'b0, Am} * {4'b0, Bm};
    s2_m <= s1_m;
  end

  always #5 clk = ~clk;

  mult_exhaustive_evaluator #(.WIDTH(W), .PIPE_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .A(A0), .B(B0), .P(P0),
    .busy(busy0), .done(done0), .err_count(cnt0), .err_sum(sum0),
    .max_err(max0), .wce_A(wa0), .wce_B(wb0));

  mult_exhaustive_evaluator #(.WIDTH(W), .PIPE_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2), .P(P2),
    .busy(busy2), .done(done2), .err_count(cnt2), .err_sum(sum2),
    .max_err(max2), .wce_A(wa2), .wce_B(wb2));

  mult_exhaustive_evaluator #(.WIDTH(W), .PIPE_LAT(0)) dutm (
    .clk(clk), .rst(rst), .start(startm), .A(Am), .B(Bm), .P(Pm),
    .busy(busym), .done(donem), .err_count(cntm), .err_sum(summ),
    .max_err(maxm), .wce_A(wam), .wce_B(wbm));

  // Monitor mux: which instance the current test observes
  int             sel = 0;
  logic           m_busy, m_done;
  logic [2*W:0]   m_cnt;
  logic [4*W-1:0] m_sum;
  logic [2*W-1:0] m_max;
  logic [W-1:0]   m_wa, m_wb;

  always_comb begin
    m_busy = busy0; m_done = done0; m_cnt = cnt0; m_sum = sum0;
    m_max = max0; m_wa = wa0; m_wb = wb0;
    case (sel)
      1: begin m_busy = busy2; m_done = done2; m_cnt = cnt2; m_sum = sum2;
               m_max = max2; m_wa = wa2; m_wb = wb2; end
      2: begin m_busy = busym; m_done = donem; m_cnt = cntm; m_sum = summ;
               m_max = maxm; m_wa = wam; m_wb = wbm; end
      default: ;
    endcase
  end

  int total = 0;
  int bad = 0;

  // First-cycle snapshot after a launch
  logic         f_busy, f_done;
  logic [2*W:0] f_cnt;
  logic [4*W-1:0] f_sum;
  logic [2*W-1:0] f_max;

  // Expected metrics from the reference model
  int e_cnt, e_sum, e_max, e_wa, e_wb;
  int lat, bsy;

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start0 = v;
      1: start2 = v;
      default: startm = v;
    endcase
  endtask

  // Reference: walk pairs in sweep order (B high nibble, A low nibble).
  task automatic model();
    int a, b, ex, e;
    e_cnt = 0; e_sum = 0; e_max = 0; e_wa = 0; e_wb = 0;
    for (int k = 0; k < 256; k++) begin
      a = k % 16; b = k / 16; ex = a * b;
      e = (mp[k] > ex) ? mp[k] - ex : ex - mp[k];
      if (e != 0) e_cnt++;
      e_sum += e;
      if (e > e_max) begin e_max = e; e_wa = a; e_wb = b; end
    end
  endtask

  task automatic fill_exact();
    for (int k = 0; k < 256; k++) begin
      tbl[k] = 8'((k % 16) * (k / 16)); mp[k] = int'(tbl[k]);
    end
  endtask

  task automatic fill_lsb_drop();
    for (int k = 0; k < 256; k++) begin
      tbl[k] = 8'((k % 16) * (k / 16)) & 8'hFE; mp[k] = int'(tbl[k]);
    end
  endtask

  // Launch a sweep on one instance and time it; lat = -1 if done never rises.
  task automatic run_sweep(input int inst, input int mid, output int l, output int bn);
    l = -1; bn = 0;
    sel = inst;
    @(negedge clk);
    set_start(inst, 1'b1);
    for (int it = 1; it <= 400; it++) begin
      @(negedge clk);
      if (it == 1) begin
        set_start(inst, 1'b0);
        f_busy = m_busy; f_done = m_done; f_cnt = m_cnt; f_sum = m_sum; f_max = m_max;
      end
      if (mid != 0 && it == mid) set_start(inst, 1'b1);
      if (mid != 0 && it == mid + 1) set_start(inst, 1'b0);
      if (m_busy) bn++;
      if (m_done) begin l = it - 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({A0, B0} !== 8'd0) begin bad++; $display("FAIL reset_ab: got %0d want 0", {A0, B0}); end
    total++; if ({busy0, done0, busy2, done2} !== 4'd0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {busy0, done0, busy2, done2}); end
    total++; if ({cnt0, sum0, max0} !== '0) begin bad++; $display("FAIL reset_metrics: got cnt=%0d sum=%0d max=%0d want 0", cnt0, sum0, max0); end
    total++; if ({wa0, wb0} !== 8'd0) begin bad++; $display("FAIL reset_wce: got %0d/%0d want 0/0", wa0, wb0); end
    rst = 1'b0;
  endtask

  task automatic test_exact();
    fill_exact(); model();
    run_sweep(0, 0, lat, bsy);
    total++; if (lat !== 256) begin bad++; $display("FAIL exact_latency: got %0d want 256", lat); end
    total++; if (bsy !== 256) begin bad++; $display("FAIL exact_busy: got %0d want 256", bsy); end
    total++; if ({m_cnt, m_sum, m_max, m_wa, m_wb} !== '0) begin bad++; $display("FAIL exact_metrics: got cnt=%0d sum=%0d max=%0d want 0", m_cnt, m_sum, m_max); end
    total++; if (e_cnt !== 0) begin bad++; $display("FAIL exact_model: got %0d want 0", e_cnt); end
  endtask

  task automatic test_lsb_drop();
    fill_lsb_drop(); model();
    run_sweep(0, 0, lat, bsy);
    total++; if (m_cnt !== 9'd64 || e_cnt !== 64) begin bad++; $display("FAIL lsb_count: got %0d want 64", m_cnt); end
    total++; if (m_sum !== 16'd64) begin bad++; $display("FAIL lsb_sum: got %0d want 64", m_sum); end
    total++; if (m_max !== 8'd1) begin bad++; $display("FAIL lsb_max: got %0d want 1", m_max); end
    total++; if ({m_wa, m_wb} !== {4'd1, 4'd1}) begin bad++; $display("FAIL lsb_wce: got %0d/%0d want 1/1", m_wa, m_wb); end
  endtask

  task automatic test_corner_zero();
    fill_exact(); tbl[255] = 8'd0; mp[255] = 0; model();
    run_sweep(0, 0, lat, bsy);
    total++; if (m_cnt !== 9'd1) begin bad++; $display("FAIL corner_count: got %0d want 1", m_cnt); end
    total++; if (m_sum !== 16'd225) begin bad++; $display("FAIL corner_sum: got %0d want 225", m_sum); end
    total++; if (m_max !== 8'd225) begin bad++; $display("FAIL corner_max: got %0d want 225", m_max); end
    total++; if ({m_wa, m_wb} !== {4'd15, 4'd15}) begin bad++; $display("FAIL corner_wce: got %0d/%0d want 15/15", m_wa, m_wb); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 256; k++) begin
        tbl[k] = 8'((k % 16) * (k / 16));
        if ($urandom_range(0, 3) == 0) tbl[k] = 8'($urandom_range(0, 255));
        mp[k] = int'(tbl[k]);
      end
      model();
      run_sweep(0, 0, lat, bsy);
      total++; if (lat !== 256) begin bad++; $display("FAIL rand_latency: got %0d want 256", lat); end
      total++; if (m_cnt !== 9'(e_cnt)) begin bad++; $display("FAIL rand_count: got %0d want %0d", m_cnt, e_cnt); end
      total++; if (m_sum !== 16'(e_sum)) begin bad++; $display("FAIL rand_sum: got %0d want %0d", m_sum, e_sum); end
      total++; if (m_max !== 8'(e_max)) begin bad++; $display("FAIL rand_max: got %0d want %0d", m_max, e_max); end
      total++; if ({m_wa, m_wb} !== {4'(e_wa), 4'(e_wb)}) begin bad++; $display("FAIL rand_wce: got %0d/%0d want %0d/%0d", m_wa, m_wb, e_wa, e_wb); end
    end
  endtask

  task automatic test_pipelined();
    run_sweep(1, 0, lat, bsy);
    total++; if (lat !== 258) begin bad++; $display("FAIL pipe_latency: got %0d want 258", lat); end
    total++; if (bsy !== 258) begin bad++; $display("FAIL pipe_busy: got %0d want 258", bsy); end
    total++; if ({m_cnt, m_sum, m_max, m_wa, m_wb} !== '0) begin bad++; $display("FAIL pipe_metrics: got cnt=%0d sum=%0d max=%0d want 0", m_cnt, m_sum, m_max); end
    // Misaligned: the candidate answers two pairs late, reset left its regs at 0.
    for (int k = 0; k < 256; k++) mp[k] = (k >= 2) ? ((k - 2) % 16) * ((k - 2) / 16) : 0;
    model();
    run_sweep(2, 0, lat, bsy);
    total++; if (m_cnt === 9'd0) begin bad++; $display("FAIL misalign_nonzero: got %0d want nonzero", m_cnt); end
    total++; if (m_cnt !== 9'(e_cnt) || m_sum !== 16'(e_sum)) begin bad++; $display("FAIL misalign_metrics: got cnt=%0d sum=%0d want cnt=%0d sum=%0d", m_cnt, m_sum, e_cnt, e_sum); end
  endtask

  task automatic test_reset_mid();
    int found = 0;
    fill_lsb_drop(); model();
    sel = 0;
    @(negedge clk);
    start0 = 1'b1;
    for (int it = 1; it <= 300; it++) begin
      @(negedge clk);
      if (it == 1) start0 = 1'b0;
      if ({B0, A0} == 8'd100) begin found = 1; break; end
    end
    total++; if (found !== 1) begin bad++; $display("FAIL midrst_reach: got %0d want 1", found); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({busy0, done0, A0, B0} !== '0) begin bad++; $display("FAIL midrst_state: got busy=%0d done=%0d A=%0d B=%0d want 0", busy0, done0, A0, B0); end
    total++; if ({cnt0, sum0, max0, wa0, wb0} !== '0) begin bad++; $display("FAIL midrst_metrics: got cnt=%0d sum=%0d max=%0d want 0", cnt0, sum0, max0); end
    rst = 1'b0;
    run_sweep(0, 0, lat, bsy);
    total++; if (lat !== 256) begin bad++; $display("FAIL midrst_latency: got %0d want 256", lat); end
    total++; if (m_cnt !== 9'(e_cnt) || m_sum !== 16'(e_sum) || m_max !== 8'(e_max) || {m_wa, m_wb} !== {4'(e_wa), 4'(e_wb)}) begin
      bad++; $display("FAIL midrst_rerun: got cnt=%0d sum=%0d max=%0d want cnt=%0d sum=%0d max=%0d", m_cnt, m_sum, m_max, e_cnt, e_sum, e_max);
    end
  endtask

  task automatic test_start_ignored();
    fill_lsb_drop(); model();
    run_sweep(0, 50, lat, bsy);
    total++; if (lat !== 256) begin bad++; $display("FAIL midstart_latency: got %0d want 256", lat); end
    total++; if (m_cnt !== 9'(e_cnt) || m_sum !== 16'(e_sum)) begin bad++; $display("FAIL midstart_metrics: got cnt=%0d sum=%0d want cnt=%0d sum=%0d", m_cnt, m_sum, e_cnt, e_sum); end
    repeat (3) @(negedge clk);
    total++; if (m_done !== 1'b1 || m_cnt !== 9'(e_cnt)) begin bad++; $display("FAIL done_hold: got done=%0d cnt=%0d want done=1 cnt=%0d", m_done, m_cnt, e_cnt); end
    // Relaunch from DONE
    run_sweep(0, 0, lat, bsy);
    total++; if (f_done !== 1'b0 || f_busy !== 1'b1) begin bad++; $display("FAIL relaunch_flags: got busy=%0d done=%0d want busy=1 done=0", f_busy, f_done); end
    total++; if ({f_cnt, f_sum, f_max} !== '0) begin bad++; $display("FAIL relaunch_clear: got cnt=%0d sum=%0d max=%0d want 0", f_cnt, f_sum, f_max); end
    total++; if (lat !== 256) begin bad++; $display("FAIL relaunch_latency: got %0d want 256", lat); end
    total++; if (m_cnt !== 9'(e_cnt) || m_sum !== 16'(e_sum) || m_max !== 8'(e_max) || {m_wa, m_wb} !== {4'(e_wa), 4'(e_wb)}) begin
      bad++; $display("FAIL relaunch_results: got cnt=%0d sum=%0d max=%0d want cnt=%0d sum=%0d max=%0d", m_cnt, m_sum, m_max, e_cnt, e_sum, e_max);
    end
  endtask

  initial begin
    fill_exact();
    test_reset();
    test_exact();
    test_lsb_drop();
    test_corner_zero();
    test_random();
    test_pipelined();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
